// File: rtl/score_pkg.sv
// Shared types and constants for the score history reader and its BCD converter.
package score_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 32;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CONVERT = 3'd3,
    ST_FINISH  = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  // Decimal digits of 2^width-1: floor(width*log10(2)) + 1.
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/score_history_reader_bin2bcd_seq.sv
// Sequential double-dabble: one input bit per cycle, MSB first. The start cycle
// loads din and already performs the first shift, so a conversion takes DATA_WIDTH cycles.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BCD_DIGITS = bcd_digits(DATA_WIDTH)
) (
  input  logic                    Clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    busy_q, busy_d;

  function automatic logic [4*BCD_DIGITS-1:0] dabble(input logic [4*BCD_DIGITS-1:0] b,
                                                     input logic in_bit);
    logic [4*BCD_DIGITS-1:0] t;
    t = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    end
    return {t[4*BCD_DIGITS-2:0], in_bit};
  endfunction

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (abort) begin
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start && !busy_q) begin
      bcd_d   = dabble('0, din[DATA_WIDTH-1]);
      shift_d = din << 1;
      cnt_d   = CW'(DATA_WIDTH - 1);
      busy_d  = (DATA_WIDTH > 1);
    end else if (busy_q) begin
      bcd_d   = dabble(bcd_q, shift_q[DATA_WIDTH-1]);
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // done marks the cycle whose edge performs the final shift.
  assign done = busy_q && (cnt_q == CW'(1));
  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_history_reader.sv
// Score-view reader: fetches one score from the score RAM, converts it to BCD and
// holds it for display; next/prev browse. Optional macro: LEADING_ZERO_BLANK_EN.
module score_history_reader
  import score_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIGITS     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  ld_score,
  input  logic                  next,
  input  logic                  prev,
  input  logic [ADDR_WIDTH-1:0] write_ptr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] entry_index,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  digits_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);

  localparam int NB = bcd_digits(DATA_WIDTH);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  state_e                state_q, state_d;
  logic                  ld_q, ld_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] entry_q, entry_d;
  logic [4*DIGITS-1:0]   digits_q, digits_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            wait_q, wait_d;

  logic                  bcd_start, bcd_abort, bcd_busy, bcd_done;
  logic [4*NB-1:0]       bcd_val;
  logic [4*DIGITS-1:0]   fin_digits;
  logic                  fin_ovf;
  logic                  seen_nz;

  assign bcd_start = (state_q == ST_CONVERT) && !bcd_busy;
  assign bcd_abort = (state_q != ST_CONVERT);

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .BCD_DIGITS (NB)
  ) u_bcd (
    .Clock (Clock),
    .reset (reset),
    .start (bcd_start),
    .abort (bcd_abort),
    .din   (mem_q),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_val)
  );

  // Saturation and leading-zero blanking of the finished conversion.
  always_comb begin
    fin_ovf    = 1'b0;
    fin_digits = '0;
    seen_nz    = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i >= DIGITS && bcd_val[i*4 +: 4] != 4'd0) fin_ovf = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (i < NB) fin_digits[i*4 +: 4] = bcd_val[i*4 +: 4];
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (fin_digits[i*4 +: 4] != 4'd0) seen_nz = 1'b1;
      if (LZB_EN && !seen_nz) fin_digits[i*4 +: 4] = BCD_BLANK;
    end
    if (fin_ovf) fin_digits = {DIGITS{4'h9}};
  end

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_score;
    mem_addr_d = mem_addr_q;
    entry_d    = entry_q;
    digits_d   = digits_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    wait_d     = wait_q;
    if (!ld_score) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ld_q) begin
            entry_d = write_ptr - ADDR_WIDTH'(1);
            busy_d  = 1'b1;
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          mem_addr_d = entry_q;
          busy_d     = 1'b1;
          wait_d     = 2'(RD_LATENCY - 1);
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == 2'd0) state_d = ST_CONVERT;
          else                wait_d  = wait_q - 2'd1;
        end
        ST_CONVERT: begin
          if (bcd_done) state_d = ST_FINISH;
        end
        ST_FINISH: begin
          digits_d = fin_digits;
          ovf_d    = fin_ovf;
          busy_d   = 1'b0;
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end
        ST_HOLD: begin
          // Simultaneous next and prev cancel out and are ignored.
          if (next ^ prev) begin
            entry_d = next ? entry_q - ADDR_WIDTH'(1) : entry_q + ADDR_WIDTH'(1);
            valid_d = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_ADDR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ld_q       <= 1'b0;
      mem_addr_q <= '0;
      entry_q    <= '0;
      digits_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      mem_addr_q <= mem_addr_d;
      entry_q    <= entry_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      wait_q     <= wait_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign entry_index  = entry_q;
  assign digits       = digits_q;
  assign digits_valid = valid_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_score_history_reader.sv
// Directed bench for score_history_reader with a 1-cycle-latency score RAM model.
module tb_score_history_reader;
  import score_pkg::*;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        Clock;
  logic        reset;
  logic        ld_score;
  logic        next;
  logic        prev;
  logic [8:0]  write_ptr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_q;
  logic [8:0]  entry_index;
  logic [31:0] digits;
  logic        digits_valid;
  logic        busy;
  logic        overflow;
  logic [2:0]  dbg_state;

  logic [31:0] ram [512];
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  score_history_reader dut (
    .Clock        (Clock),
    .reset        (reset),
    .ld_score     (ld_score),
    .next         (next),
    .prev         (prev),
    .write_ptr    (write_ptr),
    .mem_addr     (mem_addr),
    .mem_q        (mem_q),
    .entry_index  (entry_index),
    .digits       (digits),
    .digits_valid (digits_valid),
    .busy         (busy),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) mem_q <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  function automatic logic [31:0] shown(input logic [31:0] plain, input logic [31:0] blanked);
    return BLANK ? blanked : plain;
  endfunction

  // Called right after the trigger (ld rise or next/prev) has been driven.
  task automatic run_fetch(input string tag, input logic [8:0] exp_entry,
                           input logic exp_ovf, input int drop_at);
    int          n;
    logic [8:0]  addr1;
    logic [31:0] exp_d;
    @(posedge Clock);
    #1;
    next  = 1'b0;
    prev  = 1'b0;
    n     = 0;
    addr1 = '0;
    while (!digits_valid && n < 200) begin
      next = (n == drop_at);
      @(posedge Clock);
      #1;
      n++;
      if (n == 1) addr1 = mem_addr;
    end
    next = 1'b0;
    exp_d = exp_q.pop_front();
    check({tag, "_latency"}, n, 35);
    check({tag, "_mem_addr"}, {23'd0, addr1}, {23'd0, exp_entry});
    check({tag, "_entry"}, {23'd0, entry_index}, {23'd0, exp_entry});
    check({tag, "_digits"}, digits, exp_d);
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check({tag, "_mem_addr"}, {23'd0, mem_addr}, 32'd0);
    check({tag, "_entry"}, {23'd0, entry_index}, 32'd0);
    check({tag, "_digits"}, digits, 32'd0);
    check({tag, "_valid"}, {31'd0, digits_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  task automatic ld_cycle(input logic [8:0] wp);
    ld_score  = 1'b0;
    tick(2);
    write_ptr = wp;
    ld_score  = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 512; i++) ram[i] = 32'd0;
    ram[4]   = 32'd1234;
    ram[511] = 32'd7;
    ram[0]   = 32'd1;
    ram[3]   = 32'hFFFF_FFFF;
    ram[10]  = 32'd99999999;
    ram[20]  = 32'd42;
    ram[21]  = 32'd0;
    ram[30]  = 32'd55;
    reset = 1'b0; ld_score = 1'b0; next = 1'b0; prev = 1'b0; write_ptr = '0;
    tick(3);
    reset = 1'b1;
    check_zero("reset");

    // Basic fetch; write_ptr moves afterwards but selection must not.
    write_ptr = 9'd5; ld_score = 1'b1;
    exp_q.push_back(shown(32'h0000_1234, 32'hFFFF_1234));
    run_fetch("wp5", 9'd4, 1'b0, -1);
    write_ptr = 9'd100;
    tick(3);
    check("hold_entry", {23'd0, entry_index}, 32'd4);
    check("hold_state", {29'd0, dbg_state}, {29'd0, ST_HOLD});

    ld_score = 1'b0;
    tick(1);
    check("ldlow_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("ldlow_valid", {31'd0, digits_valid}, 32'd0);
    check("ldlow_digits", digits, shown(32'h0000_1234, 32'hFFFF_1234));

    // write_ptr=0 wraps to 511, prev wraps to 0.
    ld_cycle(9'd0);
    exp_q.push_back(shown(32'h0000_0007, 32'hFFFF_FFF7));
    run_fetch("wp0", 9'd511, 1'b0, -1);
    prev = 1'b1;
    exp_q.push_back(shown(32'h0000_0001, 32'hFFFF_FFF1));
    run_fetch("prev_wrap", 9'd0, 1'b0, -1);

    next = 1'b1; prev = 1'b1;
    tick(1);
    next = 1'b0; prev = 1'b0;
    tick(2);
    check("both_state", {29'd0, dbg_state}, {29'd0, ST_HOLD});
    check("both_entry", {23'd0, entry_index}, 32'd0);
    check("both_valid", {31'd0, digits_valid}, 32'd1);

    // next wraps back to 511; a second next while busy is dropped.
    next = 1'b1;
    exp_q.push_back(shown(32'h0000_0007, 32'hFFFF_FFF7));
    run_fetch("next_drop", 9'd511, 1'b0, 5);
    tick(3);
    check("drop_entry", {23'd0, entry_index}, 32'd511);
    check("drop_state", {29'd0, dbg_state}, {29'd0, ST_HOLD});

    ld_cycle(9'd4);
    exp_q.push_back(32'h9999_9999);
    run_fetch("sat", 9'd3, 1'b1, -1);
    ld_cycle(9'd11);
    exp_q.push_back(32'h9999_9999);
    run_fetch("exact8", 9'd10, 1'b0, -1);

    ld_cycle(9'd21);
    exp_q.push_back(shown(32'h0000_0042, 32'hFFFF_FF42));
    run_fetch("v42", 9'd20, 1'b0, -1);
    prev = 1'b1;
    exp_q.push_back(shown(32'h0000_0000, 32'hFFFF_FFF0));
    run_fetch("v0", 9'd21, 1'b0, -1);

    // ld_score drops mid-fetch.
    ld_cycle(9'd31);
    tick(10);
    ld_score = 1'b0;
    tick(1);
    check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("abort_valid", {31'd0, digits_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_entry", {23'd0, entry_index}, 32'd30);
    check("abort_digits", digits, shown(32'h0000_0000, 32'hFFFF_FFF0));

    // Reset mid-CONVERT, then a clean restart.
    ld_cycle(9'd31);
    tick(15);
    check("pre_rst_state", {29'd0, dbg_state}, {29'd0, ST_CONVERT});
    reset = 1'b0; ld_score = 1'b0;
    tick(1);
    check_zero("midrst");
    reset = 1'b1;
    tick(1);
    ld_score = 1'b1;
    exp_q.push_back(shown(32'h0000_0055, 32'hFFFF_FF55));
    run_fetch("restart", 9'd30, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_history_reader.md
Name: score_history_reader

Overview:
Read-side companion to the score logger. The logger writes one 32-bit score per game into the 512-entry score RAM and advances its write pointer. This block runs while the score-view menu is active (ld_score). It walks the score RAM through the RAM's read port, converts the selected entry to BCD with a sequential double-dabble, and presents the digits with the entry index to the display/VGA text path. next/prev pulses browse the history.

Parameters:
ADDR_WIDTH, 9, score RAM address width (2^ADDR_WIDTH entries)
DATA_WIDTH, 32, score word width
DIGITS, 8, BCD digits presented
RD_LATENCY, 1, score RAM read latency in cycles (legal values 1 or 2)

Ports:
Clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-low
ld_score  in  1  score-view menu state active (level)
next  in  1  one-cycle pulse, step to next older entry
prev  in  1  one-cycle pulse, step to next newer entry
write_ptr  in  ADDR_WIDTH  logger's current write address (next slot to be written)
mem_addr  out  ADDR_WIDTH  registered read address to score RAM
mem_q  in  DATA_WIDTH  score RAM read data
entry_index  out  ADDR_WIDTH  address of the entry currently shown
digits  out  4*DIGITS  BCD, digit 0 in [3:0]
digits_valid  out  1  digits/entry_index stable and valid
busy  out  1  fetch/convert in progress
overflow  out  1  shown value >= 10^DIGITS (digits saturated to all 9s)

Behaviour:
- Reset (reset==0 at posedge): state IDLE. mem_addr=0, entry_index=0, digits=0, digits_valid=0, busy=0, overflow=0. Reset overrides everything, including a fetch in progress.
- States:
  - IDLE: waits for a ld_score rising edge, detected with a registered copy of ld_score.
    - On the edge: entry_index = write_ptr-1, modulo 2^ADDR_WIDTH (write_ptr=0 selects 2^ADDR_WIDTH-1). Go to ADDR.
  - ADDR (1 cycle): mem_addr<=entry_index, busy=1.
  - WAIT (RD_LATENCY cycles): then capture mem_q into the shift register.
  - CONVERT (DATA_WIDTH cycles): double-dabble, one bit per cycle, MSB first. Before each shift, add 3 to every BCD nibble >= 5. Internal BCD width is enough for DATA_WIDTH (10 digits at 32).
  - FINISH (1 cycle):
    - If any BCD digit above DIGITS is nonzero: digits=all 4'h9, overflow=1.
    - Else: digits = low DIGITS digits, overflow=0.
    - busy=0, digits_valid=1. Go to HOLD.
  - HOLD: outputs frozen.
    - next: entry_index-1, mod 2^ADDR_WIDTH.
    - prev: entry_index+1, mod 2^ADDR_WIDTH.
    - On either: digits_valid=0, go to ADDR.
    - next and prev in the same cycle: both ignored.
- Latency: trigger edge to digits_valid=1 is exactly RD_LATENCY+DATA_WIDTH+2 cycles (35 with defaults).
- next/prev while busy: dropped, not queued.
- ld_score low in any state: next cycle IDLE, digits_valid=0, busy=0. digits and entry_index hold their last values.
- write_ptr is sampled only on the trigger edge. Later logger writes do not move the selection.
- Pure reader: the block never drives RAM write enable.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: in FINISH, every digit above the most significant nonzero digit is replaced with 4'hF (blank code). Digit 0 is never blanked, so value 0 shows "0".
- Not defined: all DIGITS digits are shown, including leading zeros.
- Saturated all-9s output is unaffected by the macro.

Decomposition:
- Package score_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults
  - BCD_BLANK=4'hF
  - state enum (IDLE, ADDR, WAIT, CONVERT, FINISH, HOLD)
  - function for the number of BCD digits needed for DATA_WIDTH
- Sub-module bin2bcd_seq: start/done sequential double-dabble, parameterised by DATA_WIDTH. The top-level FSM sequences it and owns the saturation and blanking logic.

Test Plan:
- Reset mid-CONVERT (reset low 1 cycle) -> next cycle all outputs 0, state IDLE. A later ld_score edge restarts cleanly.
- write_ptr=5, RAM[4]=1234, ld_score rises -> mem_addr=4. At cycle 35: digits_valid=1, digits=32'h00001234, entry_index=4, overflow=0.
- write_ptr=0, RAM[511]=7 -> entry_index=511, digits=32'h00000007. In HOLD, prev -> entry_index=0 (wrap), RAM[0] shown after 35 cycles.
- RAM[3]=32'hFFFFFFFF (4294967295) -> digits=32'h99999999, overflow=1. RAM[3]=99999999 -> exact digits, overflow=0.
- In HOLD, next and prev in the same cycle -> no change. next during busy -> ignored. ld_score low mid-fetch -> IDLE, digits_valid=0.
- With LEADING_ZERO_BLANK_EN: RAM value 42 -> digits=32'hFFFFFF42. Value 0 -> 32'hFFFFFFF0.
